// File: rtl/pc_branch_if.sv
// pc_branch_if: bundles the branch-request inputs and the fetch-side outputs
// of the program-counter controller.
//
// Handshake semantics (single comment for the whole bundle):
//   br_taken/br_target form a one-cycle request sampled on the rising edge.
//   The controller consumes it only in RUN. In FLUSH or HALT the request is
//   dropped silently, because it comes from a squashed or post-exit
//   instruction. stall is the downstream not-ready indication. While it is
//   high the PC holds in RUN, but a taken branch is still accepted.
//
// Signals:
//   stall, br_taken, br_target        : requester -> controller
//   pc, fetch_valid, flush, halted,
//   br_misalign, br_count             : controller -> requester/fetch
// Modports: master = branch units / fetch side, slave = pc_branch_ctrl.
interface pc_branch_if #(
  parameter int PC_W = 8
);
  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic            flush;
  logic            halted;
  logic            br_misalign;
  logic [7:0]      br_count;

  modport master (
    output stall, br_taken, br_target,
    input  pc, fetch_valid, flush, halted, br_misalign, br_count
  );

  modport slave (
    input  stall, br_taken, br_target,
    output pc, fetch_valid, flush, halted, br_misalign, br_count
  );
endinterface

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: owns the program counter. It steps the PC sequentially and
// redirects it on taken branches. After a redirect it squashes wrong-path
// fetches with a FLUSH_CYCLES-long flush. It halts once the exit label
// (HALT_PC) has been issued.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   bus       : pc_branch_if.slave (stall/br_taken/br_target in;
//               pc/fetch_valid/flush/halted/br_misalign/br_count out)
//   dbg_state : current FSM state (0=RUN, 1=FLUSH, 2=HALT)
//
// All outputs are flops or are decoded from the state register only, so no
// input has a combinational path to an output.
module pc_branch_ctrl #(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] RESET_PC     = PC_W'(4),
  parameter int              STEP         = 4,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] HALT_PC      = PC_W'(128)
) (
  input  logic        clk,
  input  logic        rst,
  pc_branch_if.slave  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);
  localparam logic [1:0]      FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            br_misalign_q, br_misalign_d;
  logic [7:0]      br_count_q, br_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fcnt_d        = fcnt_q;
    br_misalign_d = 1'b0;
    br_count_d    = br_count_q;

    case (state_q)
      ST_RUN: begin
        // A branch comes from an older instruction, so it beats stall and halt.
        if (bus.br_taken) begin
          pc_d          = {bus.br_target[PC_W-1:2], 2'b00};
          state_d       = ST_FLUSH;
          fcnt_d        = FLUSH_INIT;
          br_misalign_d = |bus.br_target[1:0];
          if (br_count_q != 8'hFF) br_count_d = br_count_q + 8'd1;
        end else if (pc_q == HALT_PC && !bus.stall) begin
          // HALT_PC was issued in this cycle; stop here with the pc frozen.
          state_d = ST_HALT;
        end else if (!bus.stall) begin
          pc_d = pc_q + STEP_V;  // wraps modulo 2^PC_W
        end
      end
      ST_FLUSH: begin
        // Requests arriving here belong to squashed instructions.
        if (fcnt_q == 2'd0) state_d = ST_RUN;
        else                fcnt_d  = fcnt_q - 2'd1;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Registered from the next state. The first cycle after reset therefore
    // shows RUN with fetch_valid still low.
    fetch_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      fcnt_q        <= 2'd0;
      fetch_valid_q <= 1'b0;
      br_misalign_q <= 1'b0;
      br_count_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fcnt_q        <= fcnt_d;
      fetch_valid_q <= fetch_valid_d;
      br_misalign_q <= br_misalign_d;
      br_count_q    <= br_count_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = (state_q == ST_FLUSH);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.br_misalign = br_misalign_q;
  assign bus.br_count    = br_count_q;
  assign dbg_state       = state_q;

endmodule
